// File: rtl/neuron_accum_seq.sv
// rtl/neuron_accum_seq.sv - sequencing FSM for one neuron's FP32 accumulate-then-bias job
//
// Drives an external fixed-latency FP32 adder one add at a time: N_INPUTS
// product adds chained through the running sum, then one bias add.
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   start, abort           job request (IDLE only) / synchronous cancel
//   bias                   FP32 bias, sampled on the accepted start
//   in_data/in_valid/in_ready/in_index   product stream and next-product index
//   add_opa/add_opb/add_go/add_result    external adder issue and result
//   out_data/out_valid/out_ready         pre-activation result stream
//   busy                   high whenever the FSM is not in IDLE
module neuron_accum_seq #(
    parameter int N_INPUTS    = 4,
    parameter int ADD_LATENCY = 6,
    parameter int INDEX_W     = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               abort,
    input  logic [31:0]        bias,
    input  logic [31:0]        in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [INDEX_W-1:0] in_index,
    output logic [31:0]        add_opa,
    output logic [31:0]        add_opb,
    output logic               add_go,
    input  logic [31:0]        add_result,
    output logic [31:0]        out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_BIAS,
        S_DONE
    } state_t;

    localparam int                 CNT_W    = $clog2(ADD_LATENCY + 1);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(ADD_LATENCY);
    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(N_INPUTS - 1);

    state_t             r_state;
    logic [31:0]        r_acc;
    logic [31:0]        r_bias;
    logic [INDEX_W-1:0] r_idx;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic               r_is_bias;
    logic               r_in_ready;
    logic [31:0]        r_add_opa;
    logic [31:0]        r_add_opb;
    logic               r_add_go;
    logic [31:0]        r_out_data;
    logic               r_out_valid;
    logic               r_busy;

    assign in_ready  = r_in_ready;
    assign in_index  = r_idx;
    assign add_opa   = r_add_opa;
    assign add_opb   = r_add_opb;
    assign add_go    = r_add_go;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_bias      <= '0;
            r_idx       <= '0;
            r_wait_cnt  <= '0;
            r_is_bias   <= 1'b0;
            r_in_ready  <= 1'b0;
            r_add_opa   <= '0;
            r_add_opb   <= '0;
            r_add_go    <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // add_go is a single-cycle strobe; only the issuing states raise it.
            r_add_go <= 1'b0;
            if (abort && (r_state != S_IDLE)) begin
                // Any in-flight adder result is simply never captured.
                r_state     <= S_IDLE;
                r_in_ready  <= 1'b0;
                r_out_valid <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            r_acc      <= '0;
                            r_idx      <= '0;
                            r_bias     <= bias;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        if (in_valid) begin
                            r_add_opa  <= r_acc;
                            r_add_opb  <= in_data;
                            r_add_go   <= 1'b1;
                            r_wait_cnt <= '0;
                            r_is_bias  <= 1'b0;
                            r_in_ready <= 1'b0;
                            r_state    <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                        // Counter is 0 in the add_go cycle, so it equals the
                        // latency exactly when add_result is valid.
                        if (r_wait_cnt == LAST_CNT) begin
                            r_acc <= add_result;
                            if (r_is_bias) begin
                                r_out_data  <= add_result;
                                r_out_valid <= 1'b1;
                                r_state     <= S_DONE;
                            end else if (r_idx == LAST_IDX) begin
                                r_state <= S_BIAS;
                            end else begin
                                r_idx      <= r_idx + INDEX_W'(1);
                                r_in_ready <= 1'b1;
                                r_state    <= S_FETCH;
                            end
                        end
                    end
                    S_BIAS: begin
                        r_add_opa  <= r_acc;
                        r_add_opb  <= r_bias;
                        r_add_go   <= 1'b1;
                        r_wait_cnt <= '0;
                        r_is_bias  <= 1'b1;
                        r_state    <= S_WAIT;
                    end
                    S_DONE: begin
                        if (out_ready) begin
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_neuron_accum_seq.sv
// tb/tb_neuron_accum_seq.sv - directed scoreboard bench for neuron_accum_seq
module tb_neuron_accum_seq;

    localparam int          LA      = 6;
    localparam int          LB      = 1;
    localparam logic [31:0] GARBAGE = 32'h7FC0_DEAD;
    localparam logic [31:0] EXP_A   = 32'h4128_0000;
    localparam logic [31:0] BIAS_A  = 32'h3F00_0000;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: default parameters
    logic        a_start = 0, a_abort = 0, a_in_valid = 0, a_out_ready = 0;
    logic [31:0] a_bias = 0, a_in_data = 0, a_add_result = GARBAGE;
    logic        a_in_ready, a_add_go, a_out_valid, a_busy;
    logic [7:0]  a_in_index;
    logic [31:0] a_add_opa, a_add_opb, a_out_data;

    // Instance B: N_INPUTS=1, ADD_LATENCY=1
    logic        b_start = 0, b_abort = 0, b_in_valid = 0, b_out_ready = 0;
    logic [31:0] b_bias = 0, b_in_data = 0, b_add_result = GARBAGE;
    logic        b_in_ready, b_add_go, b_out_valid, b_busy;
    logic [7:0]  b_in_index;
    logic [31:0] b_add_opa, b_add_opb, b_out_data;

    neuron_accum_seq u_a (
        .clk(clk), .rstn(rstn), .start(a_start), .abort(a_abort), .bias(a_bias),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_index(a_in_index), .add_opa(a_add_opa), .add_opb(a_add_opb),
        .add_go(a_add_go), .add_result(a_add_result), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .busy(a_busy)
    );

    neuron_accum_seq #(.N_INPUTS(1), .ADD_LATENCY(LB), .INDEX_W(8)) u_b (
        .clk(clk), .rstn(rstn), .start(b_start), .abort(b_abort), .bias(b_bias),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_index(b_in_index), .add_opa(b_add_opa), .add_opb(b_add_opb),
        .add_go(b_add_go), .add_result(b_add_result), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .busy(b_busy)
    );

    function automatic real f2r(input logic [31:0] b);
        real r;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        e = int'(b[30:23]);
        r = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return b[31] ? -r : r;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          ex;
        if (r == 0.0) return 32'd0;
        d  = $realtobits(r);
        ex = int'(d[62:52]) - 896;
        return {d[63], ex[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fpadd(input logic [31:0] x, input logic [31:0] y);
        return r2f(f2r(x) + f2r(y));
    endfunction

    // Behavioural fixed-latency adders; result bus carries junk outside the valid cycle.
    logic        a_pv[LA] = '{default: 1'b0};
    logic [31:0] a_pd[LA];
    logic        b_pv[LB] = '{default: 1'b0};
    logic [31:0] b_pd[LB];
    int          a_go_cnt = 0, b_go_cnt = 0;

    always @(negedge clk) begin
        a_add_result = a_pv[LA-1] ? a_pd[LA-1] : GARBAGE;
        for (int i = LA - 1; i > 0; i--) begin
            a_pv[i] = a_pv[i-1];
            a_pd[i] = a_pd[i-1];
        end
        a_pv[0] = a_add_go;
        a_pd[0] = fpadd(a_add_opa, a_add_opb);
        if (a_add_go) a_go_cnt++;
        b_add_result = b_pv[LB-1] ? b_pd[LB-1] : GARBAGE;
        b_pv[0] = b_add_go;
        b_pd[0] = fpadd(b_add_opa, b_add_opb);
        if (b_add_go) b_go_cnt++;
    end

    logic [31:0] prod[4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    logic [31:0] sb_q[$];
    int npass = 0;
    int ntotal = 0;

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic sb_pop(input string tag, input logic [31:0] obs);
        if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        else chk({tag, "_sb"}, obs, sb_q.pop_front());
    endtask

    // One job on instance A. stall_len: cycles in_valid withheld before product 2.
    // abort_at: cycle (relative to start) to abort, 0 = none. hold: cycles of out_ready low.
    task automatic a_job(input string tag, input int stall_len, input int abort_at,
                         input int hold, input bit start_in_done, input int exp_lat);
        int          t0, acc_cnt, stall_left, go0;
        bit          seen;
        logic [31:0] held;
        a_bias = BIAS_A;
        a_start = 1;
        t0 = cyc;
        go0 = a_go_cnt;
        acc_cnt = 0;
        stall_left = stall_len;
        if (abort_at == 0) sb_q.push_back(EXP_A);
        tick;
        a_start = 0;
        seen = 0;
        for (int n = 0; n < 300 && !seen; n++) begin
            if (abort_at != 0 && (cyc - t0) == abort_at) begin
                a_abort = 1;
                a_in_valid = 0;
                tick;
                a_abort = 0;
                chk({tag, "_abort_ctl"}, {28'd0, a_busy, a_in_ready, a_out_valid, a_add_go}, 32'd0);
                return;
            end
            if (a_out_valid) begin
                seen = 1;
            end else begin
                if (a_in_ready && acc_cnt == 1 && stall_left > 0) begin
                    a_in_valid = 0;
                    chk({tag, "_stall_index"}, {24'd0, a_in_index}, 32'd1);
                    stall_left--;
                end else begin
                    a_in_valid = 1;
                    a_in_data = prod[acc_cnt & 3];
                    if (a_in_ready) begin
                        chk({tag, "_in_index"}, {24'd0, a_in_index}, 32'(acc_cnt));
                        acc_cnt++;
                    end
                end
                tick;
            end
        end
        a_in_valid = 0;
        chk({tag, "_out_valid_seen"}, {31'd0, seen}, 32'd1);
        if (!seen) return;
        chk({tag, "_latency"}, 32'(cyc - t0), 32'(exp_lat));
        chk({tag, "_go_count"}, 32'(a_go_cnt - go0), 32'd5);
        held = a_out_data;
        for (int i = 0; i < hold; i++) begin
            a_out_ready = 0;
            a_start = start_in_done && (i == 0);
            tick;
            a_start = 0;
        end
        if (hold > 0) begin
            chk({tag, "_hold_valid"}, {31'd0, a_out_valid}, 32'd1);
            chk({tag, "_hold_data"}, a_out_data, held);
        end
        a_out_ready = 1;
        tick;
        a_out_ready = 0;
        sb_pop(tag, held);
        chk({tag, "_idle_after"}, {30'd0, a_out_valid, a_busy}, 32'd0);
        if (start_in_done) begin
            tick;
            chk({tag, "_start_not_queued"}, {30'd0, a_busy, a_in_ready}, 32'd0);
        end
    endtask

    initial begin
        int          t0, go0;
        bit          seen;
        #2 rstn = 0;
        tick;
        tick;
        chk("reset_ctl", {28'd0, a_busy, a_in_ready, a_out_valid, a_add_go}, 32'd0);
        chk("reset_data", a_add_opa | a_add_opb | a_out_data | {24'd0, a_in_index}, 32'd0);
        chk("reset_b_ctl", {28'd0, b_busy, b_in_ready, b_out_valid, b_add_go}, 32'd0);
        rstn = 1;
        tick;

        // abort beats start in IDLE
        a_start = 1;
        a_abort = 1;
        tick;
        a_start = 0;
        a_abort = 0;
        chk("abort_start_idle", {30'd0, a_busy, a_in_ready}, 32'd0);
        tick;

        a_job("basic", 0, 0, 0, 0, 41);
        a_job("stall", 3, 0, 0, 0, 44);
        a_job("hold", 0, 0, 5, 1, 41);
        a_job("abort", 0, 12, 0, 0, 0);
        a_job("post_abort", 0, 0, 0, 0, 41);

        // asynchronous reset in the middle of a WAIT
        a_start = 1;
        a_bias = BIAS_A;
        tick;
        a_start = 0;
        a_in_valid = 1;
        a_in_data = prod[0];
        tick;
        tick;
        tick;
        chk("pre_reset_busy", {31'd0, a_busy}, 32'd1);
        #2 rstn = 0;
        #1;
        chk("async_reset_ctl", {28'd0, a_busy, a_in_ready, a_out_valid, a_add_go}, 32'd0);
        chk("async_reset_data", a_add_opa | a_add_opb | a_out_data | {24'd0, a_in_index}, 32'd0);
        a_in_valid = 0;
        tick;
        rstn = 1;
        tick;
        a_job("after_reset", 0, 0, 0, 0, 41);

        // single-input, latency-1 configuration
        b_bias = 32'hBF80_0000;
        b_start = 1;
        t0 = cyc;
        go0 = b_go_cnt;
        sb_q.push_back(32'h3F80_0000);
        tick;
        b_start = 0;
        b_in_valid = 1;
        b_in_data = 32'h4000_0000;
        seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
            if (b_out_valid) seen = 1;
            else tick;
        end
        b_in_valid = 0;
        chk("b_out_valid_seen", {31'd0, seen}, 32'd1);
        chk("b_latency", 32'(cyc - t0), 32'd7);
        chk("b_go_count", 32'(b_go_cnt - go0), 32'd2);
        b_out_ready = 1;
        tick;
        b_out_ready = 0;
        sb_pop("b", b_out_data);
        chk("b_idle_after", {30'd0, b_out_valid, b_busy}, 32'd0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
